inst_seq: RTL

INST_SEQ -- requirements
Module: inst_seq

---
 rtl/inst_seq_pkg.sv | 39 +++
 rtl/inst_seq_addr_cnt.sv | 27 ++
 rtl/inst_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/inst_seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// word bit positions and the quiescent (IDLE) instruction value.
package inst_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_MEM,
    X_MEM,
    W_L0,
    K_LOAD,
    GAP,
    X_EXEC,
    DRAIN,
    FIN
  } state_t;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 12;

  localparam int ACC_BIT       = 33;
  localparam int PSUM_CEN      = 32;
  localparam int PSUM_WEN      = 31;
  localparam int PSUM_ADDR_LSB = 20;
  localparam int XMEM_CEN      = 19;
  localparam int XMEM_WEN      = 18;
  localparam int XMEM_ADDR_LSB = 7;
  localparam int OFIFO_RD      = 6;
  localparam int IFIFO_WR      = 5;
  localparam int IFIFO_RD      = 4;
  localparam int L0_RD         = 3;
  localparam int L0_WR         = 2;
  localparam int EXECUTE       = 1;
  localparam int LOAD          = 0;

  // SRAM enables are active-low, so the idle word keeps both CEN/WEN pairs high.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

endpackage

// File: rtl/inst_seq_addr_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// The terminal value is an input so one counter can serve phases of
// different lengths.
module addr_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  assign at_term = (count == term);

  // Count up on enable, hold at the terminal value, clear has priority.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !at_term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/inst_seq.sv
// Instruction sequencer: streams weights and activations into SRAM, loads
// the L0/PE array, executes, and drains the output FIFO into psum SRAM.
module inst_seq
  import inst_seq_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int LEN     = 36
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [row*bw-1:0]   din,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic                ofifo_valid,
  output logic [INST_W-1:0]   inst,
  output logic [row*bw-1:0]   D_xmem,
  output logic                xw_mode,
  output logic                sfp_reset,
  output logic                busy,
  output logic                done
);

  // Reject parameter sets the address fields and psum width cannot hold.
  if (LEN < 1 || LEN > 2048 || psum_bw < 2 * bw) begin : g_param_check
    $error("inst_seq: unsupported parameter combination");
  end

  state_t state, state_next;

  logic [CNT_W-1:0] x_cnt, x_term, p_cnt;
  logic             x_en, x_at_term, p_en, p_at_term, cnt_clr;
  logic             rd_fire, pend_wr;

  // Every state starts its phase with both counters at zero.
  assign cnt_clr = (state_next != state);

  addr_cnt #(.W(CNT_W)) u_xcnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clr),
    .en      (x_en),
    .term    (x_term),
    .count   (x_cnt),
    .at_term (x_at_term)
  );

  addr_cnt #(.W(CNT_W)) u_pcnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clr),
    .en      (p_en),
    .term    (CNT_W'(LEN - 1)),
    .count   (p_cnt),
    .at_term (p_at_term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // An ofifo read this cycle becomes a psum write next cycle.
  always_ff @(posedge clk) begin
    if (reset) pend_wr <= 1'b0;
    else       pend_wr <= rd_fire;
  end

  // Next-state logic and per-state instruction/handshake outputs.
  always_comb begin
    state_next = state;
    inst       = IDLE_INST;
    D_xmem     = '0;
    xw_mode    = 1'b0;
    din_ready  = 1'b0;
    sfp_reset  = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    x_en       = 1'b0;
    x_term     = '0;
    p_en       = 1'b0;
    rd_fire    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sfp_reset  = 1'b1;
          state_next = W_MEM;
        end
      end

      W_MEM, X_MEM: begin
        din_ready = 1'b1;
        xw_mode   = (state == W_MEM);
        x_term    = (state == W_MEM) ? CNT_W'(col - 1) : CNT_W'(LEN - 1);
        if (din_valid) begin
          x_en                                = 1'b1;
          D_xmem                              = din;
          inst[XMEM_CEN]                      = 1'b0;
          inst[XMEM_WEN]                      = 1'b0;
          inst[XMEM_ADDR_LSB +: ADDR_W]       = ADDR_W'(x_cnt);
          if (x_at_term) begin
            state_next = (state == W_MEM) ? X_MEM : W_L0;
          end
        end
      end

      W_L0: begin
        xw_mode = 1'b1;
        x_term  = CNT_W'(col);
        x_en    = 1'b1;
        if (x_cnt < CNT_W'(col)) begin
          inst[XMEM_CEN]                = 1'b0;
          inst[XMEM_ADDR_LSB +: ADDR_W] = ADDR_W'(x_cnt);
        end
        if (x_cnt != '0) inst[L0_WR] = 1'b1;
        if (x_at_term)   state_next  = K_LOAD;
      end

      K_LOAD: begin
        x_term      = CNT_W'(col + row - 1);
        x_en        = 1'b1;
        inst[L0_RD] = 1'b1;
        inst[LOAD]  = 1'b1;
        if (x_at_term) state_next = GAP;
      end

      GAP: begin
        state_next = X_EXEC;
      end

      X_EXEC: begin
        x_term = CNT_W'(LEN + row);
        x_en   = 1'b1;
        if (x_cnt < CNT_W'(LEN)) begin
          inst[XMEM_CEN]                = 1'b0;
          inst[XMEM_ADDR_LSB +: ADDR_W] = ADDR_W'(x_cnt);
        end
        if (x_cnt != '0 && x_cnt <= CNT_W'(LEN)) inst[L0_WR] = 1'b1;
        if (x_cnt != '0) begin
          inst[L0_RD]   = 1'b1;
          inst[EXECUTE] = 1'b1;
        end
        if (x_at_term) state_next = DRAIN;
      end

      DRAIN: begin
        x_term         = CNT_W'(LEN);
        rd_fire        = ofifo_valid && !x_at_term;
        x_en           = rd_fire;
        inst[OFIFO_RD] = rd_fire;
        inst[ACC_BIT]  = 1'b0;
        if (pend_wr) begin
          p_en                          = 1'b1;
          inst[PSUM_CEN]                = 1'b0;
          inst[PSUM_WEN]                = 1'b0;
          inst[PSUM_ADDR_LSB +: ADDR_W] = ADDR_W'(p_cnt);
          if (p_at_term) state_next = FIN;
        end
      end

      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
